imm_decode_pipe: RTL and testbench

//  Pipelined, XLEN-parametrised immediate decoder for the fetch->decode path.
//  - Accepts instructions over valid/ready and returns the sign-extended immediate, its format code,
//    the PC-relative target (pc+imm) and an illegal flag.
//  - Registered output, 2-entry skid buffer: full throughput under backpressure.
//  - Replaces the combinational immediate generator. Adds RV64 shamt handling, target add and legality checks.

---
 rtl/imm_decode_pipe.sv | 261 ++++++++++++++++++++++++++
 tb/tb_imm_decode_pipe.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_pipe.sv
// -----------------------------------------------------------------------------
// imm_decode_pipe
//
// Pipelined immediate decoder between fetch and decode. Each accepted
// instruction is decoded on the way in: the sign-extended immediate, its
// format code, an illegal flag, and the PC-relative target (pc + imm) are all
// stored. The results drain through a 2-entry FIFO whose head drives the
// outputs directly, so out_* come straight from registers.
//
// Parameters
//   XLEN        datapath width, 32 or 64
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst_n       synchronous active-low reset
//   flush       drop every buffered entry (branch redirect)
//   in_valid    in_instr / in_pc are valid
//   in_ready    block can take an instruction this cycle (registered)
//   in_instr    raw 32-bit instruction word
//   in_pc       PC of in_instr
//   out_valid   out_* hold a decoded entry
//   out_ready   consumer takes the head entry this cycle
//   out_imm     decoded immediate
//   out_fmt     0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT
//   out_target  out_pc + out_imm, modulo 2^XLEN
//   out_pc      PC passed through
//   out_illegal encoding this block cannot decode
// -----------------------------------------------------------------------------
module imm_decode_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    // Only RV32 and RV64 widths make sense for this decoder.
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_decode_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    localparam bit IS64 = (XLEN == 64);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    localparam logic [4:0] OP_LOAD     = 5'b00000;
    localparam logic [4:0] OP_OPIMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC    = 5'b00101;
    localparam logic [4:0] OP_OPIMM32  = 5'b00110;
    localparam logic [4:0] OP_STORE    = 5'b01000;
    localparam logic [4:0] OP_LUI      = 5'b01101;
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [4:0] OP_JAL      = 5'b11011;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        logic [2:0]      fmt;
        logic            ill;
    } entry_t;

    logic [4:0]      op;
    logic [2:0]      f3;
    logic            is_shift;
    logic            shift_ok;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;
    entry_t          new_entry;

    logic [1:0] count;
    logic [1:0] count_next;
    logic       ready_q;
    logic       push;
    logic       pop;
    logic       tail_slot;
    entry_t     head;
    entry_t     tail;

    assign op = in_instr[6:2];
    assign f3 = in_instr[14:12];

    // Every format sign-extends from instr[31]; the signed casts do that.
    assign imm_i = XLEN'($signed(in_instr[31:20]));
    assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                  in_instr[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                  in_instr[30:21], 1'b0}));
    assign imm_u = XLEN'($signed({in_instr[31:12], 12'h000}));

    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // Shift-immediate funct check. On RV64 the funct field shrinks to
    // instr[31:26] because instr[25] becomes the top shamt bit. Right shifts
    // may additionally set bit 30 (arithmetic variant).
    always_comb begin
        shift_ok = 1'b0;
        if (f3 == 3'b001) begin
            shift_ok = IS64 ? (in_instr[31:26] == 6'b000000)
                            : (in_instr[31:25] == 7'b0000000);
        end else begin
            shift_ok = IS64 ? (in_instr[31:26] == 6'b000000 ||
                               in_instr[31:26] == 6'b010000)
                            : (in_instr[31:25] == 7'b0000000 ||
                               in_instr[31:25] == 7'b0100000);
        end
    end

    // Opcode decode. Non-32-bit encodings (instr[1:0] != 11) are reported as
    // illegal with no immediate.
    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            dec_ill = 1'b1;
        end else begin
            case (op)
                OP_OPIMM: begin
                    if (is_shift) begin
                        dec_fmt = FMT_SHAMT;
                        dec_imm = IS64 ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
                        dec_ill = !shift_ok || (!IS64 && in_instr[25]);
                    end else begin
                        dec_fmt = FMT_I;
                        dec_imm = imm_i;
                    end
                end
                OP_OPIMM32: begin
                    // The word-sized ops only exist on RV64.
                    if (!IS64) begin
                        dec_ill = 1'b1;
                    end else if (is_shift) begin
                        dec_fmt = FMT_SHAMT;
                        dec_imm = XLEN'(in_instr[24:20]);
                        dec_ill = !shift_ok;
                    end else begin
                        dec_fmt = FMT_I;
                        dec_imm = imm_i;
                    end
                end
                OP_LOAD: begin
                    dec_fmt = FMT_I;
                    dec_imm = imm_i;
                end
                OP_JALR: begin
                    dec_fmt = FMT_I;
                    dec_imm = imm_i;
                    dec_ill = (f3 != 3'b000);
                end
                OP_STORE: begin
                    dec_fmt = FMT_S;
                    dec_imm = imm_s;
                end
                OP_BRANCH: begin
                    dec_fmt = FMT_B;
                    dec_imm = imm_b;
                end
                OP_JAL: begin
                    dec_fmt = FMT_J;
                    dec_imm = imm_j;
                end
                OP_LUI, OP_AUIPC: begin
                    dec_fmt = FMT_U;
                    dec_imm = imm_u;
                end
                default: begin
                    dec_fmt = FMT_NONE;
                end
            endcase
        end
    end

    // The target add happens at enqueue so it never sits on the output path.
    always_comb begin
        new_entry        = '0;
        new_entry.imm    = dec_imm;
        new_entry.target = in_pc + dec_imm;
        new_entry.pc     = in_pc;
        new_entry.fmt    = dec_fmt;
        new_entry.ill    = dec_ill;
    end

    // FIFO bookkeeping. A push lands in the tail slot whenever the head is
    // still occupied after this cycle's pop; otherwise it becomes the head.
    assign push      = in_valid && ready_q;
    assign pop       = (count != 2'd0) && out_ready;
    assign tail_slot = (count == 2'd2) || (count == 2'd1 && !pop);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    // Storage and the registered ready. Reset takes priority over flush; a
    // flush discards the whole FIFO and ignores this cycle's handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= 2'd0;
            ready_q <= 1'b0;
            head    <= '0;
            tail    <= '0;
        end else if (flush) begin
            count   <= 2'd0;
            ready_q <= 1'b1;
        end else begin
            count   <= count_next;
            ready_q <= (count_next != 2'd2);
            if (pop && count == 2'd2) begin
                head <= tail;
            end
            if (push) begin
                if (tail_slot) begin
                    tail <= new_entry;
                end else begin
                    head <= new_entry;
                end
            end
        end
    end

    assign in_ready    = ready_q;
    assign out_valid   = (count != 2'd0);
    assign out_imm     = head.imm;
    assign out_fmt     = head.fmt;
    assign out_target  = head.target;
    assign out_pc      = head.pc;
    assign out_illegal = head.ill;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_decode_pipe
//
// Drives an RV32 and an RV64 instance of imm_decode_pipe from the same
// stimulus. Directed vectors come from a table; the handshake, flush and reset
// corner cases and a random stream are checked against a queue-based model
// that decodes instructions straight from the ISA field definitions.
// -----------------------------------------------------------------------------
module tb_imm_decode_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32, out_target32, out_pc32;
    logic [2:0]  out_fmt32;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64, out_target64, out_pc64;
    logic [2:0]  out_fmt64;

    always #5 clk = ~clk;

    imm_decode_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_target(out_target32),
        .out_pc(out_pc32), .out_illegal(out_illegal32)
    );

    imm_decode_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_target(out_target64),
        .out_pc(out_pc64), .out_illegal(out_illegal64)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [63:0] imm32, tgt32, pc32;
        logic [63:0] imm64, tgt64, pc64;
        logic [2:0]  fmt32, fmt64;
        logic        ill32, ill64;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] tgt32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
        logic [63:0] tgt64;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    bit   model_rdy;

    // Reference decode written from the ISA field layout.
    function automatic dec_t ref_decode(input int xlen, input logic [31:0] w);
        dec_t       d;
        logic [4:0] op;
        logic [2:0] f3;
        bit         bad_funct;
        d.imm = 64'd0;
        d.fmt = 3'd0;
        d.ill = 1'b0;
        op = w[6:2];
        f3 = w[14:12];
        bad_funct = w[31] || (w[29:26] != 4'd0) || (xlen == 32 && w[25]) ||
                    (f3 == 3'b001 && w[30]);
        if (w[1:0] != 2'b11) begin
            d.ill = 1'b1;
        end else begin
            case (op)
                5'b00100, 5'b00110: begin
                    if (op == 5'b00110 && xlen == 32) begin
                        d.ill = 1'b1;
                    end else if (f3 == 3'b001 || f3 == 3'b101) begin
                        d.fmt = 3'd6;
                        d.imm = (xlen == 64 && op == 5'b00100) ? 64'(w[25:20]) : 64'(w[24:20]);
                        d.ill = bad_funct;
                    end else begin
                        d.fmt = 3'd1;
                        d.imm = 64'($signed(w[31:20]));
                    end
                end
                5'b00000: begin
                    d.fmt = 3'd1;
                    d.imm = 64'($signed(w[31:20]));
                end
                5'b11001: begin
                    d.fmt = 3'd1;
                    d.imm = 64'($signed(w[31:20]));
                    d.ill = (f3 != 3'b000);
                end
                5'b01000: begin
                    d.fmt = 3'd2;
                    d.imm = 64'($signed({w[31:25], w[11:7]}));
                end
                5'b11000: begin
                    d.fmt = 3'd3;
                    d.imm = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
                end
                5'b11011: begin
                    d.fmt = 3'd5;
                    d.imm = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
                end
                5'b01101, 5'b00101: begin
                    d.fmt = 3'd4;
                    d.imm = 64'($signed({w[31:12], 12'h000}));
                end
                default: d.fmt = 3'd0;
            endcase
        end
        if (xlen == 32) d.imm = d.imm & 64'hFFFF_FFFF;
        return d;
    endfunction

    function automatic exp_t make_exp(input logic [31:0] w, input logic [63:0] pc);
        exp_t e;
        dec_t a;
        dec_t b;
        a = ref_decode(32, w);
        b = ref_decode(64, w);
        e.imm32 = a.imm;
        e.fmt32 = a.fmt;
        e.ill32 = a.ill;
        e.pc32  = {32'd0, pc[31:0]};
        e.tgt32 = (pc + a.imm) & 64'hFFFF_FFFF;
        e.imm64 = b.imm;
        e.fmt64 = b.fmt;
        e.ill64 = b.ill;
        e.pc64  = pc;
        e.tgt64 = pc + b.imm;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          r;
        w = $urandom;
        r = $urandom_range(0, 9);
        case (r)
            0: w[6:0] = 7'b0000011;
            1: w[6:0] = 7'b0010011;
            2: w[6:0] = 7'b0011011;
            3: w[6:0] = 7'b0100011;
            4: w[6:0] = 7'b1100011;
            5: w[6:0] = 7'b1100111;
            6: w[6:0] = 7'b1101111;
            7: w[6:0] = 7'b0110111;
            8: w[6:0] = 7'b0010111;
            default: ;
        endcase
        // Clear the funct bits half the time so legal shifts show up often.
        if ($urandom_range(0, 1) == 1) begin
            w[31]    = 1'b0;
            w[29:26] = 4'd0;
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkEntry(input string tag, input exp_t e);
        chk({tag, "_imm32"}, {32'd0, out_imm32}, e.imm32);
        chk({tag, "_fmt32"}, {61'd0, out_fmt32}, {61'd0, e.fmt32});
        chk({tag, "_ill32"}, {63'd0, out_illegal32}, {63'd0, e.ill32});
        chk({tag, "_tgt32"}, {32'd0, out_target32}, e.tgt32);
        chk({tag, "_pc32"}, {32'd0, out_pc32}, e.pc32);
        chk({tag, "_imm64"}, out_imm64, e.imm64);
        chk({tag, "_fmt64"}, {61'd0, out_fmt64}, {61'd0, e.fmt64});
        chk({tag, "_ill64"}, {63'd0, out_illegal64}, {63'd0, e.ill64});
        chk({tag, "_tgt64"}, out_target64, e.tgt64);
        chk({tag, "_pc64"}, out_pc64, e.pc64);
    endtask

    task automatic chkResetState(input string tag);
        chk({tag, "_out_valid32"}, {63'd0, out_valid32}, 64'd0);
        chk({tag, "_in_ready32"}, {63'd0, in_ready32}, 64'd0);
        chk({tag, "_out_valid64"}, {63'd0, out_valid64}, 64'd0);
        chk({tag, "_in_ready64"}, {63'd0, in_ready64}, 64'd0);
        chk({tag, "_imm32"}, {32'd0, out_imm32}, 64'd0);
        chk({tag, "_tgt32"}, {32'd0, out_target32}, 64'd0);
        chk({tag, "_pc32"}, {32'd0, out_pc32}, 64'd0);
        chk({tag, "_fmtill32"}, {60'd0, out_fmt32, out_illegal32}, 64'd0);
        chk({tag, "_imm64"}, out_imm64, 64'd0);
        chk({tag, "_tgt64"}, out_target64, 64'd0);
        chk({tag, "_pc64"}, out_pc64, 64'd0);
        chk({tag, "_fmtill64"}, {60'd0, out_fmt64, out_illegal64}, 64'd0);
    endtask

    // Compares both DUTs against the model FIFO after each clock edge.
    task automatic checkOutput();
        logic exp_valid;
        exp_valid = (q.size() != 0);
        chk("out_valid32", {63'd0, out_valid32}, {63'd0, exp_valid});
        chk("out_valid64", {63'd0, out_valid64}, {63'd0, exp_valid});
        chk("in_ready32", {63'd0, in_ready32}, {63'd0, model_rdy});
        chk("in_ready64", {63'd0, in_ready64}, {63'd0, model_rdy});
        if (exp_valid) checkEntry("head", q[0]);
    endtask

    // Drives one cycle of inputs and advances the model by the handshakes
    // it predicts for that cycle.
    task automatic applyStimulus(input bit iv, input logic [31:0] w, input logic [63:0] pc,
                                 input bit ordy, input bit fl,
                                 output bit acc, output bit popped);
        in_valid  = iv;
        in_instr  = w;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        acc       = iv && model_rdy && !fl;
        popped    = (q.size() != 0) && ordy && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (popped) void'(q.pop_front());
            if (acc) q.push_back(make_exp(w, pc));
        end
        @(posedge clk);
        #1;
        flush     = 1'b0;
        model_rdy = (q.size() < 2);
        checkOutput();
    endtask

    vec_t        vecs[17];
    logic [31:0] bp[4];
    bit          acc;
    bit          popped;
    int          idx;
    int          pops;
    exp_t        e;

    initial begin
        vecs[0]  = '{32'hFFF00093, 64'h1000, 64'hFFFFFFFF, 3'd1, 1'b0, 64'hFFF,
                     64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 64'hFFF};
        vecs[1]  = '{32'h4030D093, 64'h0, 64'h3, 3'd6, 1'b0, 64'h3, 64'h3, 3'd6, 1'b0, 64'h3};
        vecs[2]  = '{32'hFE000EE3, 64'h100, 64'hFFFFFFFC, 3'd3, 1'b0, 64'hFC,
                     64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0, 64'hFC};
        vecs[3]  = '{32'h0000006F, 64'hFFFFFFFC, 64'h0, 3'd5, 1'b0, 64'hFFFFFFFC,
                     64'h0, 3'd5, 1'b0, 64'hFFFFFFFC};
        vecs[4]  = '{32'h0080006F, 64'hFFFFFFFFFFFFFFFC, 64'h8, 3'd5, 1'b0, 64'h4,
                     64'h8, 3'd5, 1'b0, 64'h4};
        vecs[5]  = '{32'h123450B7, 64'h0, 64'h12345000, 3'd4, 1'b0, 64'h12345000,
                     64'h12345000, 3'd4, 1'b0, 64'h12345000};
        vecs[6]  = '{32'h800000B7, 64'h0, 64'h80000000, 3'd4, 1'b0, 64'h80000000,
                     64'hFFFFFFFF80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000};
        vecs[7]  = '{32'h03F09093, 64'h0, 64'h1F, 3'd6, 1'b1, 64'h1F, 64'h3F, 3'd6, 1'b0, 64'h3F};
        vecs[8]  = '{32'h00000013, 64'h40, 64'h0, 3'd1, 1'b0, 64'h40, 64'h0, 3'd1, 1'b0, 64'h40};
        vecs[9]  = '{32'h00000010, 64'h40, 64'h0, 3'd0, 1'b1, 64'h40, 64'h0, 3'd0, 1'b1, 64'h40};
        vecs[10] = '{32'h80001067, 64'h2000, 64'hFFFFF800, 3'd1, 1'b1, 64'h1800,
                     64'hFFFFFFFFFFFFF800, 3'd1, 1'b1, 64'h1800};
        vecs[11] = '{32'hFE112E23, 64'h10, 64'hFFFFFFFC, 3'd2, 1'b0, 64'hC,
                     64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0, 64'hC};
        vecs[12] = '{32'h0010909B, 64'h0, 64'h0, 3'd0, 1'b1, 64'h0, 64'h1, 3'd6, 1'b0, 64'h1};
        vecs[13] = '{32'h00001097, 64'h10, 64'h1000, 3'd4, 1'b0, 64'h1010,
                     64'h1000, 3'd4, 1'b0, 64'h1010};
        vecs[14] = '{32'h2030D093, 64'h0, 64'h3, 3'd6, 1'b1, 64'h3, 64'h3, 3'd6, 1'b1, 64'h3};
        vecs[15] = '{32'h4230D093, 64'h0, 64'h3, 3'd6, 1'b1, 64'h3, 64'h23, 3'd6, 1'b0, 64'h23};
        vecs[16] = '{32'h0000007F, 64'h8, 64'h0, 3'd0, 1'b0, 64'h8, 64'h0, 3'd0, 1'b0, 64'h8};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_pc = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        chkResetState("reset");
        rst_n = 1'b1;
        q.delete();
        model_rdy = 1'b0;
        applyStimulus(1'b0, 32'd0, 64'd0, 1'b0, 1'b0, acc, popped);

        // Directed decode vectors, one at a time through an empty FIFO.
        $display("[TB] directed vectors");
        for (int i = 0; i < 17; i++) begin
            in_valid  = 1'b1;
            in_instr  = vecs[i].instr;
            in_pc     = vecs[i].pc;
            out_ready = 1'b0;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_valid32", i), {63'd0, out_valid32}, 64'd1);
            chk($sformatf("tbl%0d_valid64", i), {63'd0, out_valid64}, 64'd1);
            e.imm32 = vecs[i].imm32; e.fmt32 = vecs[i].fmt32; e.ill32 = vecs[i].ill32;
            e.tgt32 = vecs[i].tgt32; e.pc32  = {32'd0, vecs[i].pc[31:0]};
            e.imm64 = vecs[i].imm64; e.fmt64 = vecs[i].fmt64; e.ill64 = vecs[i].ill64;
            e.tgt64 = vecs[i].tgt64; e.pc64  = vecs[i].pc;
            checkEntry($sformatf("tbl%0d", i), e);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        model_rdy = 1'b1;

        // Backpressure: four instructions, consumer stalls for three cycles.
        $display("[TB] backpressure");
        bp[0] = 32'hFFF00093; bp[1] = 32'hFE000EE3; bp[2] = 32'h123450B7; bp[3] = 32'h0000006F;
        idx  = 0;
        pops = 0;
        for (int c = 0; c < 20 && (idx < 4 || q.size() != 0); c++) begin
            if (idx < 4) applyStimulus(1'b1, bp[idx], 64'h400 + 64'(idx * 4), c >= 3, 1'b0, acc, popped);
            else         applyStimulus(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, acc, popped);
            if (acc) idx++;
            if (popped) pops++;
            if (c == 2) begin
                chk("bp_accepted_before_stall", 64'(idx), 64'd2);
                chk("bp_in_ready_low", {63'd0, in_ready32}, 64'd0);
            end
        end
        chk("bp_all_emerged", 64'(pops), 64'd4);

        // Flush with two entries buffered and a word presented.
        $display("[TB] flush");
        applyStimulus(1'b1, 32'h00100093, 64'h500, 1'b0, 1'b0, acc, popped);
        applyStimulus(1'b1, 32'h00200093, 64'h504, 1'b0, 1'b0, acc, popped);
        applyStimulus(1'b1, 32'h00300093, 64'h508, 1'b1, 1'b1, acc, popped);
        chk("flush_out_valid", {63'd0, out_valid32}, 64'd0);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, acc, popped);

        // Reset mid-stream.
        $display("[TB] mid-stream reset");
        applyStimulus(1'b1, 32'h00400093, 64'h600, 1'b0, 1'b0, acc, popped);
        applyStimulus(1'b1, 32'h00500093, 64'h604, 1'b0, 1'b0, acc, popped);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chkResetState("midreset");
        q.delete();
        model_rdy = 1'b0;
        rst_n     = 1'b1;
        applyStimulus(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, acc, popped);
        chk("after_reset_in_ready", {63'd0, in_ready32}, 64'd1);

        // Random traffic with occasional flushes.
        $display("[TB] random stream");
        for (int c = 0; c < 500; c++) begin
            applyStimulus($urandom_range(0, 9) < 7, rand_instr(), {$urandom, $urandom},
                          $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, acc, popped);
        end
        for (int c = 0; c < 10 && q.size() != 0; c++) begin
            applyStimulus(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, acc, popped);
        end
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
